// File: rtl/i2c_tx_engine.sv
// I2C master write engine: START, address+W, up to 16 FIFO bytes MSB-first
// with ACK checking after every byte, then STOP. SCL/SDA are open-drain style
// drives (1 releases the line, 0 pulls it low).
module i2c_tx_engine #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] address,
  input  logic [4:0] byte_count,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_request,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       nack_error,
  output logic       underflow_error,
  output logic [4:0] bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_LOAD,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_t;

  localparam logic [15:0] QTERM = 16'(CLK_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] q_cnt;
  logic [1:0]  qidx;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [4:0]  count_q;
  logic        ack_bit;
  logic [1:0]  pop_cnt;
  logic        done_q;
  logic        nack_q;
  logic        under_q;
  logic [4:0]  sent_q;

  logic tick;
  logic accept;
  logic cell_end;
  logic in_ack;

  assign tick     = (q_cnt == QTERM);
  assign accept   = (state_q == S_IDLE) && start;
  assign cell_end = tick && (qidx == 2'd3);
  assign in_ack   = (state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK);

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign nack_error      = nack_q;
  assign underflow_error = under_q;
  assign bytes_sent      = sent_q;
  assign fifo_rd_request = (pop_cnt != 2'd0);

  // Next-state and line drive decode; LOAD takes the first cycle of the next quarter
  always_comb begin
    state_d = state_q;
    scl_o   = 1'b1;
    sda_o   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        sda_o = (qidx == 2'd0);
        if (tick && qidx == 2'd1) state_d = S_ADDR;
      end
      S_ADDR, S_DATA: begin
        scl_o = qidx[1];
        sda_o = shreg[7];
        if (cell_end && bit_idx == 3'd7)
          state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        scl_o = qidx[1];
        sda_o = 1'b1;
        if (cell_end) begin
          if (ack_bit)
            state_d = S_STOP;
          else if (sent_q == count_q)
            state_d = S_STOP;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        scl_o   = 1'b0;
        sda_o   = 1'b1;
        state_d = fifo_empty ? S_STOP : S_DATA;
      end
      S_STOP: begin
        scl_o = (qidx != 2'd0);
        sda_o = (qidx == 2'd2);
        if (tick && qidx == 2'd2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and free-running quarter counter, restarted on accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_cnt   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept || tick)
        q_cnt <= 16'd0;
      else
        q_cnt <= q_cnt + 16'd1;
    end
  end

  // Quarter/bit position, shift register and ACK sample within the current phase
  always_ff @(posedge clk) begin
    if (reset) begin
      qidx    <= 2'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      count_q <= 5'd0;
      ack_bit <= 1'b0;
    end else if (accept) begin
      qidx    <= 2'd0;
      bit_idx <= 3'd0;
      shreg   <= {address, 1'b0};
      count_q <= (byte_count > 5'd16) ? 5'd16 : byte_count;
      ack_bit <= 1'b0;
    end else begin
      if (tick)
        qidx <= (state_d != state_q) ? 2'd0 : qidx + 2'd1;
      if (cell_end && (state_q == S_ADDR || state_q == S_DATA)) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
      end
      if (in_ack && tick && qidx == 2'd2)
        ack_bit <= sda_i;
      if (state_q == S_LOAD && !fifo_empty)
        shreg <= fifo_rd_data;
    end
  end

  // Status flags, byte counter, done pulse and the two-cycle FIFO pop request
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      under_q <= 1'b0;
      sent_q  <= 5'd0;
      pop_cnt <= 2'd0;
    end else begin
      done_q <= (state_q == S_STOP) && (state_d == S_IDLE);
      if (state_q == S_LOAD && !fifo_empty)
        pop_cnt <= 2'd2;
      else if (pop_cnt != 2'd0)
        pop_cnt <= pop_cnt - 2'd1;
      if (accept) begin
        nack_q  <= 1'b0;
        under_q <= 1'b0;
        sent_q  <= 5'd0;
      end else begin
        if (state_q == S_DATA_ACK && tick && qidx == 2'd2 && !sda_i && sent_q < 5'd16)
          sent_q <= sent_q + 5'd1;
        if (in_ack && cell_end && ack_bit)
          nack_q <= 1'b1;
        if (state_q == S_LOAD && fifo_empty)
          under_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Self-checking bench for i2c_tx_engine: a FIFO model, a bus-level slave that
// decodes START/bytes/STOP and answers ACK/NACK, and a transaction-level
// reference model computing the expected outcome of each write.
module tb_i2c_tx_engine;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] address;
  logic [4:0] byte_count;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;
  logic       fifo_rd_request;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic       nack_error;
  logic       underflow_error;
  logic [4:0] bytes_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // FIFO model state
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_total = 0;
  logic prev_req = 1'b0;
  int req_len = 0;
  int bad_width = 0;

  // Bus slave / monitor state
  logic slave_sda = 1'b1;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int in_xfer = 0;
  int bit_cnt = 0;
  int byte_idx = 0;
  logic [7:0] shift = 8'd0;
  logic [7:0] bus_q[$];
  int start_seen = 0;
  int stop_seen = 0;
  int nack_at = -1;

  logic [7:0] stim_q[$];

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr[9:0]];
  assign sda_i        = sda_o & slave_sda;

  i2c_tx_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .address(address),
    .byte_count(byte_count),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_request(fifo_rd_request),
    .sda_i(sda_i),
    .scl_o(scl_o),
    .sda_o(sda_o),
    .busy(busy),
    .done(done),
    .nack_error(nack_error),
    .underflow_error(underflow_error),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO pop on request rising edge, pulse width tracking, and I2C slave
  initial begin
    logic line;
    forever begin
      @(negedge clk);
      line = sda_i;
      if (fifo_rd_request === 1'b1 && prev_req === 1'b0) begin
        rd_ptr++;
        pop_total++;
      end
      if (fifo_rd_request === 1'b1) req_len++;
      else begin
        if (req_len != 0 && req_len != 2) bad_width++;
        req_len = 0;
      end
      prev_req = fifo_rd_request;
      if (prev_scl === 1'b1 && scl_o === 1'b1 && prev_sda === 1'b1 && line === 1'b0) begin
        start_seen++;
        in_xfer = 1;
        bit_cnt = 0;
        byte_idx = 0;
        shift = 8'd0;
        slave_sda = 1'b1;
      end else if (prev_scl === 1'b1 && scl_o === 1'b1 && prev_sda === 1'b0 && line === 1'b1) begin
        stop_seen++;
        in_xfer = 0;
        slave_sda = 1'b1;
      end else if (in_xfer != 0) begin
        if (prev_scl === 1'b0 && scl_o === 1'b1) begin
          if (bit_cnt < 8) begin
            shift = {shift[6:0], line};
            bit_cnt++;
            if (bit_cnt == 8) bus_q.push_back(shift);
          end else begin
            bit_cnt = 9;
          end
        end else if (prev_scl === 1'b1 && scl_o === 1'b0) begin
          if (bit_cnt == 8) begin
            slave_sda = (byte_idx == nack_at) ? 1'b1 : 1'b0;
          end else if (bit_cnt == 9) begin
            slave_sda = 1'b1;
            bit_cnt = 0;
            byte_idx++;
          end
        end
      end
      prev_scl = scl_o;
      prev_sda = line;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flushFifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic loadFifo();
    flushFifo();
    for (int i = 0; i < stim_q.size(); i++) begin
      fifo_mem[wr_ptr[9:0]] = stim_q[i];
      wr_ptr++;
    end
  endtask

  task automatic waitDone(input int budget, output bit seen);
    seen = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
  endtask

  // Runs one write transaction and checks it against the reference model
  task automatic applyStimulus(input string name, input logic [6:0] addr, input int bc, input int nack_pos);
    logic [7:0] exp_bus[$];
    int ebc, nfifo, exp_pops, exp_sent, base_bus, base_pop, base_stop, t0;
    bit exp_nack, exp_under, seen;
    nfifo = stim_q.size();
    loadFifo();
    nack_at = nack_pos;
    address = addr;
    byte_count = bc[4:0];
    ebc = (bc > 16) ? 16 : bc;
    exp_bus.push_back({addr, 1'b0});
    exp_nack = 0;
    exp_under = 0;
    exp_sent = 0;
    exp_pops = 0;
    if (nack_pos == 0) exp_nack = 1;
    else begin
      for (int k = 0; k < ebc; k++) begin
        if (k >= nfifo) begin
          exp_under = 1;
          break;
        end
        exp_pops++;
        exp_bus.push_back(stim_q[k]);
        if (nack_pos == k + 1) begin
          exp_nack = 1;
          break;
        end
        exp_sent++;
      end
    end
    base_bus = bus_q.size();
    base_pop = pop_total;
    base_stop = stop_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, ".busy_rise"}, 32'(busy), 32'd1);
    t0 = cyc;
    waitDone(6000, seen);
    checkOutput({name, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, ".busy_at_done"}, 32'(busy), 32'd0);
      checkOutput({name, ".nack"}, 32'(nack_error), 32'(exp_nack));
      checkOutput({name, ".underflow"}, 32'(underflow_error), 32'(exp_under));
      checkOutput({name, ".bytes_sent"}, 32'(bytes_sent), 32'(exp_sent));
      checkOutput({name, ".pops"}, 32'(pop_total - base_pop), 32'(exp_pops));
      checkOutput({name, ".fifo_left"}, 32'(wr_ptr - rd_ptr), 32'(nfifo - exp_pops));
      checkOutput({name, ".stops"}, 32'(stop_seen - base_stop), 32'd1);
      checkOutput({name, ".bus_len"}, 32'(bus_q.size() - base_bus), 32'(exp_bus.size()));
      for (int i = 0; i < exp_bus.size(); i++)
        if (base_bus + i < bus_q.size())
          checkOutput({name, ".bus_byte"}, 32'(bus_q[base_bus + i]), 32'(exp_bus[i]));
      if (!exp_nack && !exp_under)
        checkOutput({name, ".latency"}, 32'(cyc - t0), 32'((5 + 36 * (1 + ebc)) * CLK_DIV));
      @(negedge clk);
      checkOutput({name, ".done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int bc, r, np;
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 8'd0;
    reset = 1'b1;
    start = 1'b0;
    address = 7'd0;
    byte_count = 5'd0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst.scl", 32'(scl_o), 32'd1);
    checkOutput("rst.sda", 32'(sda_o), 32'd1);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.req", 32'(fifo_rd_request), 32'd0);
    checkOutput("rst.nack", 32'(nack_error), 32'd0);
    checkOutput("rst.under", 32'(underflow_error), 32'd0);
    checkOutput("rst.sent", 32'(bytes_sent), 32'd0);

    $display("[TB] directed transactions");
    stim_q = '{8'hA5, 8'h3C};
    applyStimulus("basic", 7'h50, 2, -1);
    stim_q = '{8'h11, 8'h22};
    applyStimulus("addr_nack", 7'h50, 2, 0);
    stim_q = '{8'h5A};
    applyStimulus("underflow", 7'h21, 3, -1);
    stim_q = '{8'hC3, 8'h7E, 8'h81};
    applyStimulus("data_nack", 7'h3F, 3, 2);
    stim_q = '{8'h99};
    applyStimulus("zero_bytes", 7'h7F, 0, -1);
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    applyStimulus("clamp17", 7'h01, 17, -1);

    $display("[TB] random transactions");
    for (int t = 0; t < 12; t++) begin
      stim_q.delete();
      r = $urandom_range(0, 16);
      for (int i = 0; i < r; i++) stim_q.push_back(8'($urandom));
      bc = $urandom_range(0, 20);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (bc > 16) ? 16 : bc) : -1;
      applyStimulus("random", 7'($urandom_range(0, 127)), bc, np);
    end

    $display("[TB] reset mid-data");
    stim_q = '{8'hF0, 8'h0F};
    loadFifo();
    nack_at = -1;
    address = 7'h44;
    byte_count = 5'd2;
    r = pop_total;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (pop_total != r) begin
        seen = 1;
        break;
      end
    end
    checkOutput("midrst.pop_seen", 32'(seen), 32'd1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst.scl", 32'(scl_o), 32'd1);
    checkOutput("midrst.sda", 32'(sda_o), 32'd1);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.req", 32'(fifo_rd_request), 32'd0);
    checkOutput("midrst.nack", 32'(nack_error), 32'd0);
    checkOutput("midrst.under", 32'(underflow_error), 32'd0);
    checkOutput("midrst.sent", 32'(bytes_sent), 32'd0);
    checkOutput("midrst.fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    repeat (4) @(negedge clk);
    flushFifo();

    $display("[TB] start held high");
    nack_at = 0;
    address = 7'h2A;
    byte_count = 5'd1;
    @(negedge clk);
    start = 1'b1;
    waitDone(6000, seen);
    checkOutput("held.done1", 32'(seen), 32'd1);
    checkOutput("held.nack1", 32'(nack_error), 32'd1);
    nack_at = -1;
    @(negedge clk);
    checkOutput("held.busy2", 32'(busy), 32'd1);
    checkOutput("held.nack_clr", 32'(nack_error), 32'd0);
    checkOutput("held.sent_clr", 32'(bytes_sent), 32'd0);
    start = 1'b0;
    waitDone(6000, seen);
    checkOutput("held.done2", 32'(seen), 32'd1);
    checkOutput("held.under2", 32'(underflow_error), 32'd1);
    checkOutput("held.nack2", 32'(nack_error), 32'd0);
    checkOutput("held.sent2", 32'(bytes_sent), 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("pop_width", 32'(bad_width), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
